dmem_arbiter: RTL and testbench

//  Sequences and shares the single-port data memory between the MEM-stage pipeline port (CPU)
//  and a secondary DMA/loader port. Tracks fixed memory latency and issues StallM to freeze
//  the pipeline while a CPU access is pending. Arbitration is CPU-first with a DMA starvation guard.

---
 rtl/dmem_arbiter.sv | 136 +++++++++++++
 tb/tb_dmem_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter: CPU-first with a DMA starvation guard and fixed latency.
// Define DMEM_ARB_PERF_EN to build the stall/grant performance counters.
module dmem_arbiter #(
  parameter int unsigned MEM_LAT      = 1,
  parameter int unsigned DMA_MAX_WAIT = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cpu_req_i,
  input  logic        cpu_we_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_wdata_i,
  output logic [31:0] cpu_rdata_o,
  output logic        cpu_done_o,
  output logic        stall_m_o,
  input  logic        dma_req_i,
  input  logic        dma_we_i,
  input  logic [31:0] dma_addr_i,
  input  logic [31:0] dma_wdata_i,
  output logic [31:0] dma_rdata_o,
  output logic        dma_gnt_o,
  output logic        dma_done_o,
  output logic        mem_en_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  output logic [31:0] perf_cpu_stall_o,
  output logic [31:0] perf_dma_gnt_o
);

  localparam logic [2:0] LatMax  = 3'(MEM_LAT);
  localparam logic [7:0] WaitMax = 8'(DMA_MAX_WAIT);

  typedef enum logic [1:0] {StIdle, StCpu, StDma} state_e;

  state_e      state_q;
  logic [2:0]  lat_cnt_q;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        we_q;
  logic [31:0] addr_q, wdata_q;

  logic dma_win, cpu_win, last;

  always_comb begin
    dma_win = (state_q == StIdle) && dma_req_i && (!cpu_req_i || (wait_cnt_q == WaitMax));
    cpu_win = (state_q == StIdle) && cpu_req_i && !dma_win;
    last    = (state_q != StIdle) && (lat_cnt_q == LatMax);
  end

  // Waiting DMA ages every cycle it is not being served; the grant edge restarts the count.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!dma_req_i || dma_win) begin
      wait_cnt_d = 8'd0;
    end else if ((state_q != StDma) && (wait_cnt_q != WaitMax)) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      lat_cnt_q  <= 3'd0;
      wait_cnt_q <= 8'd0;
      we_q       <= 1'b0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      unique case (state_q)
        StIdle: begin
          lat_cnt_q <= 3'd0;
          if (dma_win) begin
            state_q <= StDma;
            we_q    <= dma_we_i;
            addr_q  <= dma_addr_i;
            wdata_q <= dma_wdata_i;
          end else if (cpu_win) begin
            state_q <= StCpu;
            we_q    <= cpu_we_i;
            addr_q  <= cpu_addr_i;
            wdata_q <= cpu_wdata_i;
          end
        end
        StCpu, StDma: begin
          if (last) begin
            state_q   <= StIdle;
            lat_cnt_q <= 3'd0;
          end else begin
            lat_cnt_q <= lat_cnt_q + 3'd1;
          end
        end
        default: begin
          state_q   <= StIdle;
          lat_cnt_q <= 3'd0;
        end
      endcase
    end
  end

  always_comb begin
    mem_en_o    = (state_q != StIdle);
    mem_we_o    = mem_en_o & we_q;
    mem_addr_o  = addr_q;
    mem_wdata_o = wdata_q;
    cpu_done_o  = last && (state_q == StCpu);
    dma_done_o  = last && (state_q == StDma);
    dma_gnt_o   = (state_q == StDma);
    cpu_rdata_o = cpu_done_o ? mem_rdata_i : 32'd0;
    dma_rdata_o = dma_done_o ? mem_rdata_i : 32'd0;
    // Reset must force every output low even if the CPU keeps its request up.
    stall_m_o   = cpu_req_i & ~cpu_done_o & rst_ni;
  end

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] perf_cpu_stall_q, perf_dma_gnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_cpu_stall_q <= 32'd0;
      perf_dma_gnt_q   <= 32'd0;
    end else begin
      if (stall_m_o) perf_cpu_stall_q <= perf_cpu_stall_q + 32'd1;
      if (dma_done_o) perf_dma_gnt_q <= perf_dma_gnt_q + 32'd1;
    end
  end

  assign perf_cpu_stall_o = perf_cpu_stall_q;
  assign perf_dma_gnt_o   = perf_dma_gnt_q;
`else
  assign perf_cpu_stall_o = 32'd0;
  assign perf_dma_gnt_o   = 32'd0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter (MEM_LAT=1, DMA_MAX_WAIT=8) with a 1-cycle-latency memory model.
module tb_dmem_arbiter;

  logic        clk, rst_n;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
  logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        cpu_done, stall_m, dma_gnt, dma_done, mem_en, mem_we;
  logic [31:0] perf_stall, perf_gnt;

  typedef struct {logic is_load; logic [31:0] data;} exp_t;
  exp_t cpu_q[$];
  exp_t dma_q[$];

  int checks = 0;
  int failures = 0;

  logic [31:0] mem [256];
  logic [7:0]  rd_idx;

  dmem_arbiter #(.MEM_LAT(1), .DMA_MAX_WAIT(8)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_rdata_o(cpu_rdata), .cpu_done_o(cpu_done), .stall_m_o(stall_m),
    .dma_req_i(dma_req), .dma_we_i(dma_we), .dma_addr_i(dma_addr), .dma_wdata_i(dma_wdata),
    .dma_rdata_o(dma_rdata), .dma_gnt_o(dma_gnt), .dma_done_o(dma_done),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata),
    .perf_cpu_stall_o(perf_stall), .perf_dma_gnt_o(perf_gnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read address captured on the first enabled cycle, data presented one cycle later.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
      rd_idx <= mem_addr[9:2];
    end
  end
  assign mem_rdata = mem[rd_idx];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
    step();
    step();
    @(negedge clk);
    checks++;
    if ({mem_en, mem_we, cpu_done, dma_done, dma_gnt, stall_m} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=000000",
               {mem_en, mem_we, cpu_done, dma_done, dma_gnt, stall_m});
    end
    checks++;
    if (mem_addr !== 32'd0 || cpu_rdata !== 32'd0 || dma_rdata !== 32'd0) begin
      failures++;
      $display("FAIL reset_data got=%h/%h/%h exp=0", mem_addr, cpu_rdata, dma_rdata);
    end
    checks++;
    if (perf_stall !== 32'd0 || perf_gnt !== 32'd0) begin
      failures++;
      $display("FAIL reset_perf got=%0d/%0d exp=0/0", perf_stall, perf_gnt);
    end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_store();
    exp_t e;
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h100; cpu_wdata = 32'hDEADBEEF;
    cpu_q.push_back('{is_load: 1'b0, data: 32'h0});
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (mem_en !== (k == 1 || k == 2) || mem_we !== (k == 1 || k == 2)) begin
        failures++;
        $display("FAIL store_mem_en k=%0d got=%b%b exp=%b", k, mem_en, mem_we, (k == 1 || k == 2));
      end
      checks++;
      if (stall_m !== (k <= 1)) begin
        failures++;
        $display("FAIL store_stall k=%0d got=%b exp=%b", k, stall_m, (k <= 1));
      end
      checks++;
      if (cpu_done !== (k == 2)) begin
        failures++;
        $display("FAIL store_done k=%0d got=%b exp=%b", k, cpu_done, (k == 2));
      end
      if (k == 1) begin
        checks++;
        if (mem_addr !== 32'h100 || mem_wdata !== 32'hDEADBEEF) begin
          failures++;
          $display("FAIL store_bus got=%h/%h exp=00000100/deadbeef", mem_addr, mem_wdata);
        end
      end
      if (cpu_done) begin
        checks++;
        if (cpu_q.size() == 0) begin
          failures++;
          $display("FAIL store_sb got=unexpected_done exp=none");
        end else begin
          e = cpu_q.pop_front();
        end
      end
      step();
      if (k == 2) cpu_req = 0;
    end
  endtask

  task automatic test_load(input logic [31:0] addr, input logic [31:0] data);
    exp_t e;
    bit   seen = 0;
    cpu_req = 1; cpu_we = 0; cpu_addr = addr; cpu_wdata = 32'h0;
    cpu_q.push_back('{is_load: 1'b1, data: data});
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (cpu_done) begin
        seen = 1;
        checks++;
        if (k != 2) begin
          failures++;
          $display("FAIL load_latency got=%0d exp=2", k);
        end
        checks++;
        if (stall_m !== 1'b0) begin
          failures++;
          $display("FAIL load_stall_on_done got=%b exp=0", stall_m);
        end
        checks++;
        if (cpu_q.size() == 0) begin
          failures++;
          $display("FAIL load_sb got=unexpected_done exp=none");
        end else begin
          e = cpu_q.pop_front();
          if (cpu_rdata !== e.data) begin
            failures++;
            $display("FAIL load_rdata got=%h exp=%h", cpu_rdata, e.data);
          end
        end
      end
      step();
      if (seen) begin
        cpu_req = 0;
        break;
      end
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL load_timeout got=no_done exp=done");
      cpu_req = 0;
    end
  endtask

  task automatic test_contention();
    exp_t e;
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h200; cpu_wdata = 32'hCAFEF00D;
    dma_req = 1; dma_we = 0; dma_addr = 32'h200; dma_wdata = 32'h0;
    cpu_q.push_back('{is_load: 1'b0, data: 32'h0});
    dma_q.push_back('{is_load: 1'b1, data: 32'hCAFEF00D});
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      checks++;
      if (cpu_done !== (k == 2) || dma_done !== (k == 5) || dma_gnt !== (k == 4 || k == 5)) begin
        failures++;
        $display("FAIL contention_seq k=%0d got=c%b d%b g%b exp=c%b d%b g%b", k, cpu_done,
                 dma_done, dma_gnt, (k == 2), (k == 5), (k == 4 || k == 5));
      end
      if (cpu_done && cpu_q.size() != 0) e = cpu_q.pop_front();
      if (dma_done) begin
        checks++;
        if (dma_q.size() == 0) begin
          failures++;
          $display("FAIL contention_sb got=unexpected_dma_done exp=none");
        end else begin
          e = dma_q.pop_front();
          if (dma_rdata !== e.data) begin
            failures++;
            $display("FAIL contention_dma_rdata got=%h exp=%h", dma_rdata, e.data);
          end
        end
      end
      step();
      if (k == 2) cpu_req = 0;
      if (k == 5) dma_req = 0;
    end
  endtask

  task automatic test_starvation();
    exp_t e;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h100;
    dma_req = 1; dma_we = 0; dma_addr = 32'h100;
    for (int i = 0; i < 3; i++) cpu_q.push_back('{is_load: 1'b1, data: 32'hDEADBEEF});
    dma_q.push_back('{is_load: 1'b1, data: 32'hDEADBEEF});
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      checks++;
      if (cpu_done !== (k == 2 || k == 5 || k == 8) || dma_gnt !== (k == 10 || k == 11) ||
          dma_done !== (k == 11)) begin
        failures++;
        $display("FAIL starve_seq k=%0d got=c%b g%b d%b exp=c%b g%b d%b", k, cpu_done, dma_gnt,
                 dma_done, (k == 2 || k == 5 || k == 8), (k == 10 || k == 11), (k == 11));
      end
      if (cpu_done) begin
        checks++;
        if (cpu_q.size() == 0) begin
          failures++;
          $display("FAIL starve_cpu_sb got=unexpected_done exp=none");
        end else begin
          e = cpu_q.pop_front();
          if (cpu_rdata !== e.data) begin
            failures++;
            $display("FAIL starve_cpu_rdata got=%h exp=%h", cpu_rdata, e.data);
          end
        end
      end
      if (dma_done) begin
        checks++;
        if (dma_q.size() == 0) begin
          failures++;
          $display("FAIL starve_dma_sb got=unexpected_done exp=none");
        end else begin
          e = dma_q.pop_front();
          if (dma_rdata !== e.data) begin
            failures++;
            $display("FAIL starve_dma_rdata got=%h exp=%h", dma_rdata, e.data);
          end
        end
      end
      step();
      if (k == 9) cpu_req = 0;
      if (k == 11) dma_req = 0;
    end
    checks++;
    if (cpu_q.size() != 0 || dma_q.size() != 0) begin
      failures++;
      $display("FAIL starve_sb_empty got=%0d/%0d exp=0/0", cpu_q.size(), dma_q.size());
    end
  endtask

  task automatic test_reset_mid();
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h300; cpu_wdata = 32'h0BADF00D;
    step();
    checks++;
    if (mem_en !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_pre got=%b exp=1", mem_en);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_en, stall_m, cpu_done, dma_gnt} !== 4'b0) begin
      failures++;
      $display("FAIL rstmid_async got=%b exp=0000", {mem_en, stall_m, cpu_done, dma_gnt});
    end
    cpu_req = 0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (cpu_done !== 1'b0 || mem_en !== 1'b0) begin
        failures++;
        $display("FAIL rstmid_hold k=%0d got=%b%b exp=00", k, cpu_done, mem_en);
      end
      step();
    end
    rst_n = 1'b1;
    step();
    test_load(32'h100, 32'hDEADBEEF);
  endtask

  task automatic test_perf();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    test_store();
    test_contention();
    @(negedge clk);
    checks++;
`ifdef DMEM_ARB_PERF_EN
    if (perf_stall !== 32'd4 || perf_gnt !== 32'd1) begin
      failures++;
      $display("FAIL perf got=%0d/%0d exp=4/1", perf_stall, perf_gnt);
    end
`else
    if (perf_stall !== 32'd0 || perf_gnt !== 32'd0) begin
      failures++;
      $display("FAIL perf got=%0d/%0d exp=0/0", perf_stall, perf_gnt);
    end
`endif
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    rd_idx = 8'd0;
    test_reset();
    test_store();
    test_load(32'h100, 32'hDEADBEEF);
    test_contention();
    test_starvation();
    test_reset_mid();
    test_perf();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
